// File: rtl/insn_line_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : insn_line_fill_pkg
//  Description : Shared definitions for the instruction-cache refill path.
//                Holds the cache-line bit layout used by both the refill
//                engine and the cache, and the bus-request codes the cache
//                shares with the memory side.
//  Contents    : LINE_W, CL_* layout constants, bus_req_e
//  Revision    : 1.0 - initial release
// ============================================================================
package insn_line_fill_pkg;

    // Line layout: {tag[19:0], V, L0, L1, L2, L3}
    localparam int LINE_W   = 149;
    localparam int CL_TagHi = 148;
    localparam int CL_TagLo = 129;
    localparam int CL_V     = 128;
    localparam int CL_L0Hi  = 127;
    localparam int CL_L0Lo  = 96;
    localparam int CL_L1Hi  = 95;
    localparam int CL_L1Lo  = 64;
    localparam int CL_L2Hi  = 63;
    localparam int CL_L2Lo  = 32;
    localparam int CL_L3Hi  = 31;
    localparam int CL_L3Lo  = 0;

    // Request codes exchanged with the cache
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_READ  = 2'd1,
        BUS_WRITE = 2'd2
    } bus_req_e;

endpackage
`default_nettype wire

// File: rtl/insn_line_fill_if.sv
`default_nettype none
// ============================================================================
//  Module      : insn_line_fill_if
//  Description : Bundles the cache miss handshake, the external memory bus
//                beat handshake and the line-install outputs of the refill
//                engine.
//  Modports    : master - the refill engine (drives bus and fill outputs)
//                slave  - the surrounding cache / memory environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface insn_line_fill_if;
    import insn_line_fill_pkg::*;

    // Miss request from the cache
    logic              miss_req;
    logic [31:0]       miss_addr;
    logic              miss_ack;
    // Memory bus beats
    logic              bus_req;
    logic [31:0]       bus_addr;
    logic              bus_ack;
    logic [31:0]       bus_data;
    logic              bus_err;
    // Early-forwarded critical word
    logic              crit_valid;
    logic [31:0]       crit_data;
    // Line install
    logic              fill_valid;
    logic [LINE_W-1:0] fill_line;
    logic [7:0]        fill_set;
    logic              fill_err;
    // Status
    logic              busy;
    logic [31:0]       fill_cnt;

    modport master (
        input  miss_req, miss_addr, bus_ack, bus_data, bus_err,
        output miss_ack, bus_req, bus_addr, crit_valid, crit_data,
               fill_valid, fill_line, fill_set, fill_err, busy, fill_cnt
    );

    modport slave (
        output miss_req, miss_addr, bus_ack, bus_data, bus_err,
        input  miss_ack, bus_req, bus_addr, crit_valid, crit_data,
               fill_valid, fill_line, fill_set, fill_err, busy, fill_cnt
    );

endinterface
`default_nettype wire

// File: rtl/insn_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : insn_line_fill
//  Description : Instruction-cache line refill engine. Accepts a miss,
//                fetches the 16-byte line as a critical-word-first wrapping
//                burst of four longwords, forwards the requested word early
//                and delivers the assembled line with its set index.
//  Ports       : CLK    - clock
//                nRESET - synchronous active-low reset
//                lf     - insn_line_fill_if.master (miss, bus, fill, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module insn_line_fill
    import insn_line_fill_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 20
) (
    input  wire logic         CLK,
    input  wire logic         nRESET,
    insn_line_fill_if.master  lf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e        state_q;
    logic [31:2]   addr_q;
    logic [1:0]    beat_q;
    logic [31:0]   bank_q [LINE_WORDS];
    logic [31:0]   bank_d [LINE_WORDS];
    logic          bus_req_q;
    logic [31:0]   bus_addr_q;
    logic          crit_valid_q;
    logic [31:0]   crit_data_q;
    logic          fill_valid_q;
    logic          fill_err_q;
    logic [LINE_W-1:0] fill_line_q;
    logic [7:0]    fill_set_q;
    logic          busy_q;
    logic [31:0]   fill_cnt_q;

    logic [1:0]    word_idx;
    logic [1:0]    word_idx_nxt;
    logic          beat_ok;

    // Word slot of the current beat: 2-bit wrap from the critical word
    assign word_idx     = addr_q[3:2] + beat_q;
    assign word_idx_nxt = word_idx + 2'd1;
    assign beat_ok      = (state_q == S_BEAT) && lf.bus_ack && !lf.bus_err;

    // Bank contents including the beat completing this cycle, so the last
    // beat can be folded straight into the delivered line.
    always_comb begin
        bank_d = bank_q;
        if (beat_ok) begin
            bank_d[word_idx] = lf.bus_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                bank_q[i] <= '0;
            end
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            fill_line_q  <= '0;
            fill_set_q   <= '0;
            busy_q       <= 1'b0;
            fill_cnt_q   <= '0;
        end else begin
            crit_valid_q <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lf.miss_req) begin
                        addr_q     <= lf.miss_addr[31:2];
                        beat_q     <= 2'd0;
                        bus_addr_q <= {lf.miss_addr[31:2], 2'b00};
                        bus_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (lf.bus_ack) begin
                        if (lf.bus_err) begin
                            // Partial line is simply never delivered; every
                            // slot is rewritten by the next fill.
                            bus_req_q  <= 1'b0;
                            fill_err_q <= 1'b1;
                            state_q    <= S_ERR;
                        end else begin
                            bank_q <= bank_d;
                            beat_q <= beat_q + 2'd1;
                            if (beat_q == 2'd0) begin
                                crit_valid_q <= 1'b1;
                                crit_data_q  <= lf.bus_data;
                            end
                            if (beat_q == 2'd3) begin
                                bus_req_q    <= 1'b0;
                                fill_valid_q <= 1'b1;
                                fill_cnt_q   <= fill_cnt_q + 32'd1;
                                fill_set_q   <= addr_q[11:4];
                                fill_line_q[CL_TagHi:CL_TagLo] <= addr_q[31 -: TAG_W];
                                fill_line_q[CL_V]              <= 1'b1;
                                fill_line_q[CL_L0Hi:CL_L0Lo]   <= bank_d[0];
                                fill_line_q[CL_L1Hi:CL_L1Lo]   <= bank_d[1];
                                fill_line_q[CL_L2Hi:CL_L2Lo]   <= bank_d[2];
                                fill_line_q[CL_L3Hi:CL_L3Lo]   <= bank_d[3];
                                state_q      <= S_DONE;
                            end else begin
                                bus_addr_q <= {addr_q[31:4], word_idx_nxt, 2'b00};
                            end
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Acceptance is signalled in the same cycle the request is seen in IDLE
    assign lf.miss_ack   = nRESET && (state_q == S_IDLE) && lf.miss_req;
    assign lf.bus_req    = bus_req_q;
    assign lf.bus_addr   = bus_addr_q;
    assign lf.crit_valid = crit_valid_q;
    assign lf.crit_data  = crit_data_q;
    assign lf.fill_valid = fill_valid_q;
    assign lf.fill_line  = fill_line_q;
    assign lf.fill_set   = fill_set_q;
    assign lf.fill_err   = fill_err_q;
    assign lf.busy       = busy_q;
    assign lf.fill_cnt   = fill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_insn_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_insn_line_fill
//  Description : Directed self-checking bench for insn_line_fill. Each step
//                runs a miss through a small bus responder for a fixed number
//                of cycles, records when events occur, and compares them with
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_line_fill;
    import insn_line_fill_pkg::*;

    logic CLK;
    logic nRESET;
    insn_line_fill_if lf ();

    insn_line_fill dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .lf     (lf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int npass = 0;
    int ntot  = 0;

    // Observations from the latest run()
    int          o_nack, o_ack1, o_ack2;
    logic [31:0] o_baddr [8];
    int          o_nbeat;
    int          o_crit_cyc;
    logic [31:0] o_crit_dat;
    int          o_nfv, o_fv_first, o_fv_last;
    int          o_nfe, o_fe_cyc;
    bit          o_unstable;
    logic        o_breq0, o_breq1;

    task automatic chk(input string tag, input logic [148:0] obs, input logic [148:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Cycle 0 is the first cycle the request is driven. Inputs change on the
    // falling edge; outputs are sampled 1 time unit later.
    task automatic run(input logic [31:0] addr,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3,
                       input int waits, input int err_beat,
                       input int ncyc, input bit hold);
        logic [31:0] dat [4];
        logic [31:0] cur;
        int beat;
        int wcnt;
        dat = '{d0, d1, d2, d3};
        cur = '0;
        beat = 0;
        wcnt = 0;
        o_nack = 0; o_ack1 = -1; o_ack2 = -1;
        o_nbeat = 0; o_crit_cyc = -1; o_crit_dat = '0;
        o_nfv = 0; o_fv_first = -1; o_fv_last = -1;
        o_nfe = 0; o_fe_cyc = -1; o_unstable = 1'b0;
        o_breq0 = 1'bx; o_breq1 = 1'bx;
        for (int i = 0; i < 8; i++) o_baddr[i] = 'x;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge CLK);
            lf.miss_req  = hold || (o_nack == 0);
            lf.miss_addr = addr;
            lf.bus_ack   = 1'b0;
            lf.bus_err   = 1'b0;
            if (cyc == 0) o_breq0 = lf.bus_req;
            if (cyc == 1) o_breq1 = lf.bus_req;
            if (lf.bus_req) begin
                if (wcnt == 0) cur = lf.bus_addr;
                else if (lf.bus_addr !== cur) o_unstable = 1'b1;
                if (wcnt == waits) begin
                    lf.bus_ack  = 1'b1;
                    lf.bus_data = dat[beat % 4];
                    lf.bus_err  = (beat == err_beat);
                    if (beat < 8) o_baddr[beat] = lf.bus_addr;
                    beat++;
                    o_nbeat = beat;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            #1;
            if (lf.miss_ack) begin
                if (o_nack == 0) o_ack1 = cyc; else o_ack2 = cyc;
                o_nack++;
            end
            if (lf.crit_valid) begin
                o_crit_cyc = cyc;
                o_crit_dat = lf.crit_data;
            end
            if (lf.fill_valid) begin
                if (o_nfv == 0) o_fv_first = cyc;
                o_fv_last = cyc;
                o_nfv++;
            end
            if (lf.fill_err) begin
                o_fe_cyc = cyc;
                o_nfe++;
            end
        end
    endtask

    initial begin
        nRESET       = 1'b0;
        lf.miss_req  = 1'b1;
        lf.miss_addr = 32'h0000_1230;
        lf.bus_ack   = 1'b0;
        lf.bus_data  = '0;
        lf.bus_err   = 1'b0;

        // ---------------- Reset state ----------------
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_miss_ack",   149'(lf.miss_ack),   149'(0));
        chk("rst_busy",       149'(lf.busy),       149'(0));
        chk("rst_bus_req",    149'(lf.bus_req),    149'(0));
        chk("rst_bus_addr",   149'(lf.bus_addr),   149'(0));
        chk("rst_fill_line",  lf.fill_line,        149'(0));
        chk("rst_fill_cnt",   149'(lf.fill_cnt),   149'(0));
        chk("rst_crit_data",  149'(lf.crit_data),  149'(0));
        nRESET      = 1'b1;
        lf.miss_req = 1'b0;

        // ---------------- Aligned miss, zero wait ----------------
        run(32'h0001_2340, 32'h11, 32'h22, 32'h33, 32'h44, 0, -1, 7, 1'b0);
        chk("al_ack_cyc",   149'(o_ack1),      149'(0));
        chk("al_breq_c0",   149'(o_breq0),     149'(0));
        chk("al_breq_c1",   149'(o_breq1),     149'(1));
        chk("al_addr0",     149'(o_baddr[0]),  149'(32'h0001_2340));
        chk("al_addr1",     149'(o_baddr[1]),  149'(32'h0001_2344));
        chk("al_addr2",     149'(o_baddr[2]),  149'(32'h0001_2348));
        chk("al_addr3",     149'(o_baddr[3]),  149'(32'h0001_234C));
        chk("al_crit_cyc",  149'(o_crit_cyc),  149'(2));
        chk("al_crit_dat",  149'(o_crit_dat),  149'(32'h11));
        chk("al_fv_cyc",    149'(o_fv_first),  149'(5));
        chk("al_nfv",       149'(o_nfv),       149'(1));
        chk("al_nfe",       149'(o_nfe),       149'(0));
        chk("al_set",       149'(lf.fill_set), 149'(8'h34));
        chk("al_line",      lf.fill_line,
            {20'h00012, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44});
        chk("al_cnt",       149'(lf.fill_cnt), 149'(1));
        chk("al_busy_idle", 149'(lf.busy),     149'(0));

        // ---------------- Wrapping miss ----------------
        run(32'hABCD_E00C, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, -1, 7, 1'b0);
        chk("wr_addr0",    149'(o_baddr[0]),  149'(32'hABCD_E00C));
        chk("wr_addr1",    149'(o_baddr[1]),  149'(32'hABCD_E000));
        chk("wr_addr2",    149'(o_baddr[2]),  149'(32'hABCD_E004));
        chk("wr_addr3",    149'(o_baddr[3]),  149'(32'hABCD_E008));
        chk("wr_crit_dat", 149'(o_crit_dat),  149'(32'hA0));
        chk("wr_fv_cyc",   149'(o_fv_first),  149'(5));
        chk("wr_set",      149'(lf.fill_set), 149'(8'h00));
        chk("wr_line",     lf.fill_line,
            {20'hABCDE, 1'b1, 32'hA1, 32'hA2, 32'hA3, 32'hA0});
        chk("wr_cnt",      149'(lf.fill_cnt), 149'(2));

        // ---------------- Wait states (3 per beat) ----------------
        run(32'h0000_0104, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
            3, -1, 19, 1'b0);
        chk("ws_stable",   149'(o_unstable),  149'(0));
        chk("ws_addr0",    149'(o_baddr[0]),  149'(32'h0000_0104));
        chk("ws_addr3",    149'(o_baddr[3]),  149'(32'h0000_0100));
        chk("ws_crit_cyc", 149'(o_crit_cyc),  149'(5));
        chk("ws_fv_cyc",   149'(o_fv_first),  149'(17));
        chk("ws_set",      149'(lf.fill_set), 149'(8'h10));
        chk("ws_line",     lf.fill_line,
            {20'h00000, 1'b1, 32'hC0DE_0003, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002});
        chk("ws_cnt",      149'(lf.fill_cnt), 149'(3));

        // ---------------- Bus error on beat 2 ----------------
        run(32'h0005_5550, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, 2, 6, 1'b0);
        chk("e2_fe_cyc",   149'(o_fe_cyc),    149'(4));
        chk("e2_nfe",      149'(o_nfe),       149'(1));
        chk("e2_nfv",      149'(o_nfv),       149'(0));
        chk("e2_crit_cyc", 149'(o_crit_cyc),  149'(2));
        chk("e2_cnt",      149'(lf.fill_cnt), 149'(3));
        chk("e2_set_hold", 149'(lf.fill_set), 149'(8'h10));
        chk("e2_busy",     149'(lf.busy),     149'(0));

        // ---------------- Bus error on beat 0 ----------------
        run(32'h0006_6660, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 0, 0, 4, 1'b0);
        chk("e0_fe_cyc",    149'(o_fe_cyc),     149'(2));
        chk("e0_no_crit",   149'(o_crit_cyc),   149'(-1));
        chk("e0_crit_hold", 149'(lf.crit_data), 149'(32'hE0));
        chk("e0_nfv",       149'(o_nfv),        149'(0));

        // ---------------- Busy: request held high ----------------
        run(32'h0007_7770, 32'h5A0, 32'h5A1, 32'h5A2, 32'h5A3, 0, -1, 12, 1'b1);
        lf.miss_req = 1'b0;
        chk("bb_ack1",     149'(o_ack1),      149'(0));
        chk("bb_ack2",     149'(o_ack2),      149'(6));
        chk("bb_nack",     149'(o_nack),      149'(2));
        chk("bb_fv_first", 149'(o_fv_first),  149'(5));
        chk("bb_fv_last",  149'(o_fv_last),   149'(11));
        chk("bb_set",      149'(lf.fill_set), 149'(8'h77));
        chk("bb_line",     lf.fill_line,
            {20'h00077, 1'b1, 32'h5A0, 32'h5A1, 32'h5A2, 32'h5A3});
        chk("bb_cnt",      149'(lf.fill_cnt), 149'(5));

        // ---------------- Reset during beat 1 ----------------
        run(32'h0000_0020, 32'h71, 32'h72, 32'h73, 32'h74, 0, -1, 2, 1'b0);
        @(negedge CLK);
        nRESET      = 1'b0;
        lf.miss_req = 1'b0;
        lf.bus_ack  = 1'b0;
        @(negedge CLK);
        #1;
        chk("mr_bus_req",  149'(lf.bus_req),    149'(0));
        chk("mr_busy",     149'(lf.busy),       149'(0));
        chk("mr_crit_v",   149'(lf.crit_valid), 149'(0));
        chk("mr_crit_d",   149'(lf.crit_data),  149'(0));
        chk("mr_cnt",      149'(lf.fill_cnt),   149'(0));
        chk("mr_line",     lf.fill_line,        149'(0));
        nRESET      = 1'b1;
        lf.bus_ack  = 1'b1;
        lf.bus_data = 32'hDEAD_BEEF;
        @(negedge CLK);
        #1;
        chk("mr_late_busy", 149'(lf.busy),       149'(0));
        chk("mr_late_breq", 149'(lf.bus_req),    149'(0));
        chk("mr_late_crit", 149'(lf.crit_valid), 149'(0));
        chk("mr_late_fv",   149'(lf.fill_valid), 149'(0));
        lf.bus_ack = 1'b0;

        // ---------------- Counter wrap ----------------
        @(negedge CLK);
        force dut.fill_cnt_q = 32'hFFFF_FFFF;
        @(negedge CLK);
        release dut.fill_cnt_q;
        #1;
        chk("cw_preload", 149'(lf.fill_cnt), 149'(32'hFFFF_FFFF));
        run(32'h0000_0008, 32'h1, 32'h2, 32'h3, 32'h4, 0, -1, 7, 1'b0);
        chk("cw_fv_cyc",  149'(o_fv_first),  149'(5));
        chk("cw_cnt",     149'(lf.fill_cnt), 149'(0));
        chk("cw_line",    lf.fill_line,
            {20'h00000, 1'b1, 32'h3, 32'h4, 32'h1, 32'h2});

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/insn_line_fill.md
# insn_line_fill

Instruction-cache refill engine that sits directly downstream of the instruction cache's miss path and upstream of the external memory bus. On a miss it latches the address, fetches the four longwords of the 16-byte line as a critical-word-first wrapping burst, forwards the requested word early, and hands the cache one assembled 149-bit line (20-bit tag, valid bit, L0..L3) plus its 8-bit set index for installation.

## Interface
- `LINE_WORDS`, 4: longwords per line. Fixed; it only documents the burst length.
- `TAG_W`, 20: tag width, taken from address bits [31:12].
- `CLK` in 1: clock. One clock domain; every register updates on the rising edge.
- `nRESET` in 1: reset. Synchronous, active-low.
- `miss_req` in 1: the cache requests a line fill. Level signal, held until `miss_ack`.
- `miss_addr` in 32: miss address. Bits [3:2] select the critical word; bits [1:0] are ignored.
- `miss_ack` out 1: one-cycle pulse that marks acceptance of the request.
- `bus_req` out 1: bus beat request.
- `bus_addr` out 32: longword address of the current beat. Bits [1:0] are always 0.
- `bus_ack` in 1: the beat completes in this cycle; `bus_data` is valid.
- `bus_data` in 32: read data.
- `bus_err` in 1: bus error. Sampled only when `bus_ack` is 1.
- `crit_valid` out 1: one-cycle pulse. The critical word is on `crit_data`.
- `crit_data` out 32: the early-forwarded requested longword.
- `fill_valid` out 1: one-cycle pulse. `fill_line` and `fill_set` are valid.
- `fill_line` out 149: the assembled line as {tag, 1'b1, L0, L1, L2, L3}. Tag occupies [148:129], V is [128], L0 is [127:96], L3 is [31:0].
- `fill_set` out 8: `miss_addr[11:4]` of the fill.
- `fill_err` out 1: one-cycle pulse. The fill was aborted.
- `busy` out 1: high in every state other than IDLE.
- `fill_cnt` out 32: count of completed fills. Wraps modulo 2^32.

## Operation
- States and transitions:
  - IDLE: if `miss_req`=1, pulse `miss_ack`, latch the address, set beat counter b=0, then go to BEAT.
  - BEAT: on `bus_ack` with `bus_err`=0, store the word, increment b, then:
    - if b was 3, go to DONE;
    - otherwise stay in BEAT.
  - BEAT with `bus_ack` and `bus_err`=1: go to ERR.
  - DONE: pulse `fill_valid`, increment `fill_cnt`, return to IDLE.
  - ERR: pulse `fill_err`, discard the partial line, return to IDLE.
- Beat address: {addr[31:4], w, 2'b00}, where w = (addr[3:2] + b) mod 4 (2-bit wrap). With an addr[3:2]=2 start, the order is 2, 3, 0, 1.
- Word placement: beat data is stored in slot Lw by word index, never by beat order.
- Critical word: the data captured on beat 0 is presented on `crit_data` with `crit_valid` the following cycle.
- Request handling:
  - While `busy`=1, `miss_req` is ignored. No queueing, no `miss_ack`.
  - A new request is accepted only once the FSM is back in IDLE.
- Bus handshake:
  - `bus_req` is 1 throughout BEAT.
  - `bus_addr` is stable until the `bus_ack` cycle.
  - A new address is presented the cycle after each ack.
  - Wait states are unbounded; there is no timeout.
- Outputs:
  - `fill_line` and `fill_set` hold their last value between fills.
  - `crit_data` holds its last value between critical-word pulses.
- Reset (`nRESET`=0 at an edge, in any state, including mid-burst):
  - state goes to IDLE;
  - `miss_ack`, `bus_req`, `crit_valid`, `fill_valid`, `fill_err`, `busy` all go to 0;
  - `bus_addr`, `crit_data`, `fill_line`, `fill_set`, `fill_cnt` all go to 0;
  - an in-flight beat is abandoned. A `bus_ack` arriving after reset is ignored.

## Timing
- Cycle 0: IDLE with `miss_req`=1, so `miss_ack`=1.
- Cycle 1: `bus_req`=1 with the beat-0 address.
- Zero-wait bus (ack in the same cycle as each request): beats complete in cycles 1-4.
  - `crit_valid` = 1 in cycle 2.
  - `fill_valid` = 1 in cycle 5.
  - The earliest next `miss_ack` is in cycle 6.
- Each wait state adds one cycle to every later event.
- Error on beat k (0-based) with zero-wait: `fill_err` in cycle k+2, and `fill_valid` never asserts.
- If the error is on beat 0, `crit_valid` is suppressed.
- `fill_valid` and `fill_err` are mutually exclusive. Each is exactly one cycle.

## Structure
- Shared package holds:
  - the cache-line layout constants `CL_TagHi`=148, `CL_TagLo`=129, `CL_V`=128, `CL_L0Hi`..`CL_L3Lo`;
  - the line width, 149;
  - the bus-request codes shared with the cache (none/read/write = 0/1/2).
- The FSM state encoding is local to this block.
- No sub-module. Line assembly is an inline 4×32 register bank indexed by w.

## Test plan
- Aligned miss, zero-wait:
  - Stimulus: `miss_addr`=0x00012340. Beats read 0x11, 0x22, 0x33, 0x44.
  - Response: addresses 0x12340, 0x12344, 0x12348, 0x1234C; `crit_data`=0x11 in cycle 2; `fill_valid` in cycle 5.
  - Response: `fill_set`=0x34; `fill_line` = {0x00012, 1, 0x11, 0x22, 0x33, 0x44}; `fill_cnt`=1.
- Wrapping miss:
  - Stimulus: `miss_addr`=0xABCDE00C.
  - Response: beat addresses 0x..00C, 0x..000, 0x..004, 0x..008; beat-0 data lands in L3; `crit_valid` carries the 0x..00C word.
- Wait states:
  - Stimulus: `bus_ack` delayed by 3 cycles per beat.
  - Response: `bus_addr` stable during every wait; `fill_valid` in cycle 17.
- Bus error:
  - Stimulus: `bus_err` on beat 2.
  - Response: `fill_err` pulse; no `fill_valid`; `fill_cnt` unchanged; the next miss fills cleanly.
- Busy / back-to-back:
  - Stimulus: `miss_req` held high continuously.
  - Response: the second `miss_ack` occurs only after the first `fill_valid`.
- Reset during beat 1:
  - Response: next cycle `bus_req`=0 and `busy`=0; a late `bus_ack` is ignored.
- Counter wrap:
  - Stimulus: preload `fill_cnt`=0xFFFFFFFF, then one fill.
  - Response: `fill_cnt`=0.
